stopwatch_ctrl: RTL
===================

Name: stopwatch_ctrl

Overview:
Control sequencer for the BCD stopwatch. It conditions the three raw push-buttons (speed, start/pause, reset) and runs the RUN/PAUSE/IDLE state machine. It generates a single-cycle count-enable at one of four selectable rates, replacing a derived slow clock with a clock-enable on the one system clock. It drives the BCD counter chain (tick_en, clear) and the display/status logic (running, speed_sel).

Parameters:
BASE_DIV, 1_000_000, clk cycles per tick at speed 0 (100 Hz at 100 MHz); must be a multiple of 8 and >= 8
DEBOUNCE_CYCLES, 1_000_000, consecutive stable synchronized cycles required to accept a button level change (10 ms at 100 MHz); >= 2

Ports:
clk  input  1  system clock, 100 MHz
reset_n  input  1  asynchronous active-low reset
btn_speed  input  1  raw speed button (btnU), asynchronous, bouncy
btn_pause  input  1  raw start/pause button (btnC), asynchronous, bouncy
btn_reset  input  1  raw stopwatch-clear button (btnD), asynchronous, bouncy
tick_en  output  1  one-cycle count enable to the BCD counter chain
clear  output  1  one-cycle synchronous clear to the BCD counter chain
running  output  1  high while in RUN
speed_sel  output  2  current rate: 0=1x, 1=2x, 2=4x, 3=8x

Behaviour:
- Reset (reset_n low, async): state=IDLE, speed_sel=0, prescaler=0, debounced levels=0, all sync flops=0; tick_en=0, clear=0, running=0. All outputs are registered.
- Button conditioning, per button, identical:
  - 2-FF synchronizer.
  - Debounce counter resets whenever the synced value equals the debounced level, and increments otherwise.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level takes the synced value.
  - A press pulse is a one-cycle high on the debounced level's rising edge.
  - For a raw input that rises cleanly and stays high, the press pulse appears exactly 2+DEBOUNCE_CYCLES clk edges later.
  - Releases generate no pulse.
  - A glitch shorter than DEBOUNCE_CYCLES produces nothing.
- FSM states: IDLE, RUN, PAUSE.
  - Pause press: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
  - Reset press: any state -> IDLE, with clear high for exactly 1 cycle, in the cycle after the press pulse.
  - Simultaneous reset and pause presses: reset wins, pause is ignored.
  - Speed press is accepted in every state: speed_sel = (speed_sel+1) mod 4, wrapping 3->0.
  - Simultaneous speed and pause presses: both take effect in the same cycle.
- running = (state==RUN), registered; it changes 1 cycle after the press pulse.
- Prescaler:
  - Width clog2(BASE_DIV). Divisor div = BASE_DIV >> speed_sel.
  - In RUN: if cnt==div-1 then cnt<=0 and tick_en<=1 for that one cycle; else cnt<=cnt+1.
  - In PAUSE: cnt holds; tick_en=0. Resuming preserves phase, so the first tick arrives after the remaining div-1-cnt+1 cycles.
  - In IDLE: cnt=0; tick_en=0.
  - Speed change: cnt<=0 in the same cycle, so the next tick comes a full new div after the change. No tick is emitted in the change cycle.
- First tick after IDLE->RUN: tick_en is high exactly div cycles after running rises.
- tick_en and clear are never high together. Reset press in RUN suppresses any tick due in that cycle.
- Async reset asserted mid-operation returns everything to reset values immediately. Buttons held across reset release produce a press only after a full debounce interval.

Decomposition:
- Package stopwatch_pkg:
  - state enum (IDLE, RUN, PAUSE), 2-bit.
  - speed_sel type (logic [1:0]).
  - Default BASE_DIV and DEBOUNCE_CYCLES constants.
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES; ports clk, reset_n, raw, level, press):
  - Contains the synchronizer, debounce counter and edge detect.
  - Instantiated three times.
- The FSM and prescaler live in stopwatch_ctrl.

Test Plan:
All scenarios use BASE_DIV=16 and DEBOUNCE_CYCLES=4.
1. Reset released, no buttons, 200 cycles -> tick_en, clear, running stay 0; speed_sel=0.
2. btn_pause high for 10 cycles -> press pulse 6 edges after the rise; running=1 the next cycle; tick_en pulses every 16 cycles, the first exactly 16 cycles after running rises.
3. In RUN, four separate btn_speed presses -> speed_sel 1,2,3,0; tick spacing 8,4,2,16 cycles; no tick in each change cycle; the next tick is a full div after each change.
4. RUN with cnt=5, pause press -> running=0, no ticks for 100 cycles; pause press again -> first tick after 11 cycles, then every 16.
5. btn_reset toggling every 2 cycles for 30 cycles, then low -> no press, no clear. Then btn_reset and btn_pause pressed on the same cycle while in RUN -> state IDLE, clear=1 for exactly 1 cycle, running=0, speed_sel unchanged.
6. reset_n pulled low mid-RUN at speed_sel=2 for 1 cycle -> all outputs 0 immediately, speed_sel=0; btn_pause held through the release -> press only after 2+4 edges.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and default timing constants for the stopwatch
// control sequencer.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    typedef logic [1:0] speed_t;

    localparam int unsigned BASE_DIV_DEF = 1_000_000;
    localparam int unsigned DEBOUNCE_DEF = 1_000_000;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and counter/status outputs of the stopwatch
// sequencer.
interface stopwatch_ctrl_if;
    import stopwatch_pkg::*;

    logic   btn_speed;
    logic   btn_pause;
    logic   btn_reset;
    logic   tick_en;
    logic   clear;
    logic   running;
    speed_t speed_sel;

    modport master (
        output btn_speed, btn_pause, btn_reset,
        input  tick_en, clear, running, speed_sel
    );

    modport slave (
        input  btn_speed, btn_pause, btn_reset,
        output tick_en, clear, running, speed_sel
    );

endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter
// and rising-edge press pulse.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta;
    logic          sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

    // Level only moves after a full run of disagreeing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt   <= '0;
                level <= sync;
                press <= sync;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: IDLE/RUN/PAUSE FSM plus a clock-enable
// prescaler whose divisor shrinks by powers of two with speed_sel.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned BASE_DIV        = BASE_DIV_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    stopwatch_ctrl_if.slave  bus
);

    localparam int unsigned PW = $clog2(BASE_DIV);

    logic          speed_p;
    logic          pause_p;
    logic          rst_p;
    logic [2:0]    btn_level_unused;

    state_e        state_q;
    state_e        state_d;
    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;
    logic [PW-1:0] div_m1;
    speed_t        speed_q;
    speed_t        speed_d;
    logic          tick_q;
    logic          tick_d;
    logic          clear_q;
    logic          clear_d;
    logic          run_q;
    logic          run_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_speed (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (bus.btn_speed),
        .level   (btn_level_unused[0]),
        .press   (speed_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (bus.btn_pause),
        .level   (btn_level_unused[1]),
        .press   (pause_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_reset (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (bus.btn_reset),
        .level   (btn_level_unused[2]),
        .press   (rst_p)
    );

    assign div_m1 = PW'((BASE_DIV >> speed_q) - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Reset press dominates; a simultaneous pause press is dropped.
    always_comb begin
        state_d = state_q;
        if (rst_p) begin
            state_d = IDLE;
        end else if (pause_p) begin
            unique case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        clear_d = rst_p;
        run_d   = (state_d == RUN);
        speed_d = speed_p ? speed_q + 2'd1 : speed_q;
        // A rate change restarts the phase so no short tick escapes.
        if (rst_p || speed_p || state_q == IDLE) begin
            cnt_d = '0;
        end else if (state_q == RUN) begin
            if (cnt_q == div_m1) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            speed_q <= '0;
            tick_q  <= 1'b0;
            clear_q <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            speed_q <= speed_d;
            tick_q  <= tick_d;
            clear_q <= clear_d;
            run_q   <= run_d;
        end
    end

    assign bus.tick_en   = tick_q;
    assign bus.clear     = clear_q;
    assign bus.running   = run_q;
    assign bus.speed_sel = speed_q;

endmodule
